// File: rtl/dlf_pkg.sv
// Shared types and arithmetic helpers for the gear-shifted PI loop filter.
// The saturate/abs helpers work on 32-bit signed values; callers size-cast.
package dlf_pkg;

  typedef enum logic [1:0] {
    ST_ACQ    = 2'b00,
    ST_SETTLE = 2'b01,
    ST_TRACK  = 2'b10
  } dlf_state_e;

  function automatic logic signed [31:0] sat_s(
    input logic signed [31:0] v,
    input logic signed [31:0] lo,
    input logic signed [31:0] hi
  );
    if (v < lo) begin
      return lo;
    end else if (v > hi) begin
      return hi;
    end else begin
      return v;
    end
  endfunction

  function automatic logic [31:0] abs_s(input logic signed [31:0] v);
    return (v < 0) ? 32'(-v) : 32'(v);
  endfunction

endpackage

// File: rtl/dlf_lock_det.sv
// Lock detector: ACQ -> SETTLE -> TRACK -> ACQ, advanced only on accepted
// samples. Its state selects between acquisition and tracking gains.
module dlf_lock_det
  import dlf_pkg::*;
#(
  parameter int PE_W       = 10,
  parameter int LOCK_TH    = 4,
  parameter int LOCK_CNT   = 16,
  parameter int UNLOCK_TH  = 32,
  parameter int UNLOCK_CNT = 4,
  parameter int SETTLE_CNT = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            accept,
  input  logic [PE_W:0]   pe_abs,
  output logic [1:0]      state,
  output logic            locked,
  output logic            trk_gain
);

  localparam int CNT_MAX =
    (LOCK_CNT > SETTLE_CNT) ? ((LOCK_CNT > UNLOCK_CNT) ? LOCK_CNT : UNLOCK_CNT)
                            : ((SETTLE_CNT > UNLOCK_CNT) ? SETTLE_CNT : UNLOCK_CNT);
  localparam int CW = $clog2(CNT_MAX + 1);

  localparam logic [PE_W:0] LOCK_TH_V   = (PE_W + 1)'(LOCK_TH);
  localparam logic [PE_W:0] UNLOCK_TH_V = (PE_W + 1)'(UNLOCK_TH);
  localparam logic [CW-1:0] LOCK_LAST   = CW'(LOCK_CNT - 1);
  localparam logic [CW-1:0] UNLOCK_LAST = CW'(UNLOCK_CNT - 1);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CNT - 1);

  dlf_state_e      state_reg, state_next;
  logic [CW-1:0]   lock_cnt_reg, lock_cnt_next;
  logic [CW-1:0]   unl_cnt_reg, unl_cnt_next;
  logic [CW-1:0]   set_cnt_reg, set_cnt_next;

  always_comb begin
    state_next    = state_reg;
    lock_cnt_next = lock_cnt_reg;
    unl_cnt_next  = unl_cnt_reg;
    set_cnt_next  = set_cnt_reg;
    if (accept) begin
      case (state_reg)
        ST_ACQ: begin
          if (pe_abs <= LOCK_TH_V) begin
            if (lock_cnt_reg == LOCK_LAST) begin
              state_next    = ST_SETTLE;
              lock_cnt_next = '0;
              unl_cnt_next  = '0;
              set_cnt_next  = '0;
            end else begin
              lock_cnt_next = lock_cnt_reg + CW'(1);
            end
          end else begin
            lock_cnt_next = '0;
          end
        end
        // Unlock detection is deliberately blind here while the loop settles.
        ST_SETTLE: begin
          if (set_cnt_reg == SETTLE_LAST) begin
            state_next    = ST_TRACK;
            lock_cnt_next = '0;
            unl_cnt_next  = '0;
            set_cnt_next  = '0;
          end else begin
            set_cnt_next = set_cnt_reg + CW'(1);
          end
        end
        ST_TRACK: begin
          if (pe_abs > UNLOCK_TH_V) begin
            if (unl_cnt_reg == UNLOCK_LAST) begin
              state_next    = ST_ACQ;
              lock_cnt_next = '0;
              unl_cnt_next  = '0;
              set_cnt_next  = '0;
            end else begin
              unl_cnt_next = unl_cnt_reg + CW'(1);
            end
          end else begin
            unl_cnt_next = '0;
          end
        end
        default: begin
          state_next    = ST_ACQ;
          lock_cnt_next = '0;
          unl_cnt_next  = '0;
          set_cnt_next  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_ACQ;
      lock_cnt_reg <= '0;
      unl_cnt_reg  <= '0;
      set_cnt_reg  <= '0;
    end else begin
      state_reg    <= state_next;
      lock_cnt_reg <= lock_cnt_next;
      unl_cnt_reg  <= unl_cnt_next;
      set_cnt_reg  <= set_cnt_next;
    end
  end

  assign state    = state_reg;
  assign locked   = (state_reg != ST_ACQ);
  assign trk_gain = (state_reg != ST_ACQ);

endmodule

// File: rtl/dlf_pi_gear.sv
// Digital loop filter for the ADPLL: gear-shifted PI core with a clamped
// integrator, optional one-pole smoother and a lock detector.
module dlf_pi_gear
  import dlf_pkg::*;
#(
  parameter int PE_W       = 10,
  parameter int DCW_W      = 12,
  parameter int FRAC_W     = 8,
  parameter int ACC_W      = DCW_W + FRAC_W + 2,
  parameter int DCW_INIT   = 2048,
  parameter int ORDER      = 1,
  parameter int POLE_SH    = 3,
  parameter int KP_ACQ_SH  = 2,
  parameter int KI_ACQ_SH  = 5,
  parameter int KP_TRK_SH  = 4,
  parameter int KI_TRK_SH  = 8,
  parameter int LOCK_TH    = 4,
  parameter int LOCK_CNT   = 16,
  parameter int UNLOCK_TH  = 32,
  parameter int UNLOCK_CNT = 4,
  parameter int SETTLE_CNT = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic signed [PE_W-1:0] pe,
  input  logic                   freeze,
  output logic                   out_valid,
  output logic [DCW_W-1:0]       dcw,
  output logic                   locked,
  output logic [1:0]             state
);

  localparam logic signed [31:0]      RAIL_LO  = 32'sd0;
  localparam logic signed [31:0]      RAIL_HI  = 32'((64'(1) << (DCW_W + FRAC_W)) - 64'(1));
  localparam logic signed [ACC_W-1:0] INIT_ACC = ACC_W'(DCW_INIT * (2 ** FRAC_W));

  logic            accept;
  logic [PE_W:0]   pe_abs;
  logic            trk_gain;

  // Input capture stage
  logic                   v0_reg;
  logic signed [PE_W-1:0] pe0_reg;
  logic                   trk0_reg;

  // Stage 1: integrator and proportional term
  logic                    v1_reg;
  logic signed [ACC_W-1:0] integ_reg, integ_next;
  logic signed [ACC_W-1:0] prop_reg;
  logic signed [ACC_W-1:0] x_s1, prop_s1, istep_s1;

  // Stage 2: sum, smoother and output
  logic                    out_valid_reg;
  logic signed [ACC_W-1:0] y_reg, y_next, y_smooth, s_s2;
  logic [DCW_W-1:0]        dcw_reg, dcw_next;

  assign accept = in_valid & ~freeze;
  assign pe_abs = (PE_W + 1)'(abs_s(32'(pe)));

  dlf_lock_det #(
    .PE_W       (PE_W),
    .LOCK_TH    (LOCK_TH),
    .LOCK_CNT   (LOCK_CNT),
    .UNLOCK_TH  (UNLOCK_TH),
    .UNLOCK_CNT (UNLOCK_CNT),
    .SETTLE_CNT (SETTLE_CNT)
  ) u_lock_det (
    .clk      (clk),
    .rst      (rst),
    .accept   (accept),
    .pe_abs   (pe_abs),
    .state    (state),
    .locked   (locked),
    .trk_gain (trk_gain)
  );

  // The gain set travels with the sample so a gear change never re-gains
  // samples already in flight.
  always_comb begin
    x_s1     = ACC_W'(pe0_reg) <<< FRAC_W;
    prop_s1  = trk0_reg ? (x_s1 >>> KP_TRK_SH) : (x_s1 >>> KP_ACQ_SH);
    istep_s1 = trk0_reg ? (x_s1 >>> KI_TRK_SH) : (x_s1 >>> KI_ACQ_SH);
    integ_next = ACC_W'(sat_s(32'(integ_reg) + 32'(istep_s1), RAIL_LO, RAIL_HI));
  end

  always_comb begin
    s_s2     = ACC_W'(sat_s(32'(integ_reg) + 32'(prop_reg), RAIL_LO, RAIL_HI));
    y_smooth = y_reg + ((s_s2 - y_reg) >>> POLE_SH);
    y_next   = (ORDER == 2) ? y_smooth : s_s2;
    dcw_next = DCW_W'(y_next >>> FRAC_W);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v0_reg        <= 1'b0;
      pe0_reg       <= '0;
      trk0_reg      <= 1'b0;
      v1_reg        <= 1'b0;
      integ_reg     <= INIT_ACC;
      prop_reg      <= '0;
      out_valid_reg <= 1'b0;
      y_reg         <= INIT_ACC;
      dcw_reg       <= DCW_W'(DCW_INIT);
    end else begin
      v0_reg <= accept;
      if (accept) begin
        pe0_reg  <= pe;
        trk0_reg <= trk_gain;
      end
      v1_reg <= v0_reg;
      if (v0_reg) begin
        integ_reg <= integ_next;
        prop_reg  <= prop_s1;
      end
      out_valid_reg <= v1_reg;
      if (v1_reg) begin
        y_reg   <= y_next;
        dcw_reg <= dcw_next;
      end
    end
  end

  assign out_valid = out_valid_reg;
  assign dcw       = dcw_reg;

endmodule

// File: tb/tb_dlf_pi_gear.sv
// Self-checking bench for dlf_pi_gear: directed scenarios plus a randomized
// stream, checked against an arithmetic model of the filter and lock rules.
module tb_dlf_pi_gear;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              freeze = 1'b0;
  logic signed [9:0] pe = '0;
  logic              out_valid;
  logic [11:0]       dcw;
  logic              locked;
  logic [1:0]        state;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  dlf_pi_gear dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .pe        (pe),
    .freeze    (freeze),
    .out_valid (out_valid),
    .dcw       (dcw),
    .locked    (locked),
    .state     (state)
  );

  // Reference model: state 0=ACQ 1=SETTLE 2=TRACK, values in plain integers.
  int m_state, m_lc, m_uc, m_sc, m_integ, m_dcw;
  bit m_ov;
  bit h_v [3];
  int h_d [3];

  function automatic int fshift(int x, int k);
    int d;
    d = 1 << k;
    if (x >= 0) return x / d;
    return -((-x + d - 1) / d);
  endfunction

  function automatic int clamp(int v);
    if (v < 0) return 0;
    if (v > 4096 * 256 - 1) return 4096 * 256 - 1;
    return v;
  endfunction

  task automatic model_reset();
    m_state = 0; m_lc = 0; m_uc = 0; m_sc = 0;
    m_integ = 2048 * 256;
    m_dcw = 2048;
    m_ov = 1'b0;
    for (int i = 0; i < 3; i++) begin
      h_v[i] = 1'b0;
      h_d[i] = 0;
    end
  endtask

  task automatic model_accept(input int p, output int d);
    int x, kp, ki, s, a;
    kp = (m_state == 0) ? 2 : 4;
    ki = (m_state == 0) ? 5 : 8;
    x = p * 256;
    m_integ = clamp(m_integ + fshift(x, ki));
    s = clamp(m_integ + fshift(x, kp));
    d = s / 256;
    a = (p < 0) ? -p : p;
    case (m_state)
      0: if (a <= 4) begin
           m_lc++;
           if (m_lc == 16) begin m_state = 1; m_lc = 0; m_uc = 0; m_sc = 0; end
         end else m_lc = 0;
      1: begin
           m_sc++;
           if (m_sc == 8) begin m_state = 2; m_lc = 0; m_uc = 0; m_sc = 0; end
         end
      default: if (a > 32) begin
           m_uc++;
           if (m_uc == 4) begin m_state = 0; m_lc = 0; m_uc = 0; m_sc = 0; end
         end else m_uc = 0;
    endcase
  endtask

  // One clock of stimulus; model advanced to match the state seen at edge+1.
  task automatic step(input bit r, input bit v, input bit f, input int p);
    int d;
    rst = r; in_valid = v; freeze = f; pe = p[9:0];
    @(posedge clk);
    #1;
    if (r) begin
      model_reset();
    end else begin
      h_v[2] = h_v[1]; h_d[2] = h_d[1];
      h_v[1] = h_v[0]; h_d[1] = h_d[0];
      h_v[0] = 1'b0;
      if (v && !f) begin
        model_accept(p, d);
        h_v[0] = 1'b1;
        h_d[0] = d;
      end
      m_ov = h_v[2];
      if (h_v[2]) m_dcw = h_d[2];
    end
  endtask

  task automatic test_reset();
    model_reset();
    for (int i = 0; i < 3; i++) step(1, 1, 0, 77);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
    total++; if (dcw !== 12'd2048) begin bad++; $display("FAIL reset_dcw got=%0d exp=2048", dcw); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_ov got=%0b exp=0", out_valid); end
    total++; if (state !== 2'b00) begin bad++; $display("FAIL reset_state got=%0d exp=0", state); end
    total++; if (locked !== 1'b0) begin bad++; $display("FAIL reset_locked got=%0b exp=0", locked); end
  endtask

  task automatic test_basic();
    step(0, 1, 0, 64);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL basic_lat1 got=%0b exp=0", out_valid); end
    step(0, 1, 0, 0);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL basic_lat2 got=%0b exp=0", out_valid); end
    step(0, 0, 0, 0);
    total++; if (out_valid !== 1'b1 || dcw !== 12'd2066) begin
      bad++; $display("FAIL basic_pe64 got=%0b/%0d exp=1/2066", out_valid, dcw); end
    step(0, 0, 0, 0);
    total++; if (out_valid !== 1'b1 || dcw !== 12'd2050) begin
      bad++; $display("FAIL basic_pe0 got=%0b/%0d exp=1/2050", out_valid, dcw); end
    step(0, 0, 0, 0);
    total++; if (out_valid !== 1'b0 || dcw !== 12'd2050) begin
      bad++; $display("FAIL basic_idle got=%0b/%0d exp=0/2050", out_valid, dcw); end
  endtask

  task automatic test_lock();
    for (int i = 0; i < 9; i++) step(0, 1, 0, 2);
    step(0, 1, 0, 5);
    for (int i = 1; i <= 16; i++) begin
      step(0, 1, 0, 2);
      total++; if (state !== m_state[1:0] || locked !== (m_state != 0)) begin
        bad++; $display("FAIL lock_seq%0d got=%0d/%0b exp=%0d", i, state, locked, m_state); end
      if (i == 15) begin
        total++; if (state !== 2'b00) begin bad++; $display("FAIL lock_restart got=%0d exp=0", state); end
      end
    end
    total++; if (state !== 2'b01 || locked !== 1'b1) begin
      bad++; $display("FAIL lock_settle got=%0d/%0b exp=1/1", state, locked); end
    for (int i = 1; i <= 8; i++) begin
      step(0, 1, 0, int'($urandom_range(0, 200)) - 100);
      total++; if (out_valid !== m_ov || dcw !== m_dcw[11:0]) begin
        bad++; $display("FAIL settle_out%0d got=%0b/%0d exp=%0b/%0d", i, out_valid, dcw, m_ov, m_dcw); end
      if (i == 7) begin
        total++; if (state !== 2'b01) begin bad++; $display("FAIL settle_hold got=%0d exp=1", state); end
      end
    end
    total++; if (state !== 2'b10 || locked !== 1'b1) begin
      bad++; $display("FAIL lock_track got=%0d/%0b exp=2/1", state, locked); end
  endtask

  task automatic test_unlock();
    for (int i = 0; i < 3; i++) step(0, 1, 0, 40);
    step(0, 1, 0, 0);
    total++; if (state !== 2'b10) begin bad++; $display("FAIL unlock_reset got=%0d exp=2", state); end
    for (int i = 1; i <= 4; i++) begin
      step(0, 1, 0, 40);
      total++; if (out_valid !== m_ov || dcw !== m_dcw[11:0]) begin
        bad++; $display("FAIL unlock_out%0d got=%0b/%0d exp=%0b/%0d", i, out_valid, dcw, m_ov, m_dcw); end
    end
    total++; if (state !== 2'b00 || locked !== 1'b0) begin
      bad++; $display("FAIL unlock_acq got=%0d/%0b exp=0/0", state, locked); end
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 200; i++) begin
      step(0, 1, 0, 511);
      total++; if (out_valid !== m_ov || dcw !== m_dcw[11:0]) begin
        bad++; $display("FAIL sat_ramp%0d got=%0b/%0d exp=%0b/%0d", i, out_valid, dcw, m_ov, m_dcw); end
    end
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    total++; if (dcw !== 12'd4095) begin bad++; $display("FAIL sat_rail got=%0d exp=4095", dcw); end
    step(0, 1, 0, -511);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    total++; if (out_valid !== 1'b1 || dcw !== 12'd3952) begin
      bad++; $display("FAIL sat_nowindup got=%0b/%0d exp=1/3952", out_valid, dcw); end
    step(0, 0, 0, 0);
  endtask

  task automatic test_freeze();
    logic [11:0] dcw0;
    logic [1:0]  st0;
    dcw0 = dcw; st0 = state;
    for (int i = 0; i < 5; i++) begin
      step(0, 1, 1, int'($urandom_range(0, 1023)) - 512);
      total++; if (out_valid !== 1'b0 || dcw !== dcw0 || state !== st0) begin
        bad++; $display("FAIL freeze%0d got=%0b/%0d/%0d exp=0/%0d/%0d", i, out_valid, dcw, state, dcw0, st0); end
    end
    step(0, 1, 0, -100);
    step(0, 1, 1, 300);
    step(0, 1, 1, 300);
    total++; if (out_valid !== 1'b1 || dcw !== m_dcw[11:0] || !m_ov) begin
      bad++; $display("FAIL freeze_inflight got=%0b/%0d exp=1/%0d", out_valid, dcw, m_dcw); end
    step(0, 0, 0, 0);
  endtask

  task automatic test_rst_flight();
    step(0, 1, 0, 100);
    step(1, 0, 0, 0);
    total++; if (out_valid !== 1'b0 || dcw !== 12'd2048) begin
      bad++; $display("FAIL rst_flight1 got=%0b/%0d exp=0/2048", out_valid, dcw); end
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    total++; if (out_valid !== 1'b0 || dcw !== 12'd2048 || state !== 2'b00) begin
      bad++; $display("FAIL rst_flight2 got=%0b/%0d/%0d exp=0/2048/0", out_valid, dcw, state); end
  endtask

  task automatic test_back_to_back();
    int p;
    bit v, f;
    for (int i = 0; i < 400; i++) begin
      v = ($urandom_range(0, 3) != 0);
      f = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 2) != 0) p = int'($urandom_range(0, 12)) - 6;
      else p = int'($urandom_range(0, 1023)) - 512;
      step(0, v, f, p);
      total++; if (out_valid !== m_ov || dcw !== m_dcw[11:0] || state !== m_state[1:0] || locked !== (m_state != 0)) begin
        bad++; $display("FAIL rand%0d got=%0b/%0d/%0d/%0b exp=%0b/%0d/%0d/%0b",
                        i, out_valid, dcw, state, locked, m_ov, m_dcw, m_state, m_state != 0); end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_lock();
    test_unlock();
    test_saturate();
    test_freeze();
    test_rst_flight();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
